// File: rtl/serial_pkg.sv
// serial_pkg: shared frame constants and FSM state types for serial_interface
// Contents: DATA_BITS, STOP_BITS, tx_state_t, rx_state_t
package serial_pkg;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with input synchroniser and one-entry output buffer
// Ports: clk, nrst (async active-low), i_rxd (async serial line, idle high),
//        o_data/o_valid/i_ready (ready-valid byte output; overrun drops the new byte)
module serial_rx
    import serial_pkg::*;
#(
    parameter logic [15:0] WTIME = 16'd868
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       i_rxd,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid
);
    rx_state_t   r_state, w_next;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift, r_data;
    logic        r_valid;
    logic        w_rxd, w_sample, w_load;

    assign w_rxd    = r_sync[1];
    // first sample lands mid start bit, later ones one bit period apart
    assign w_sample = r_cnt == (r_state == RX_START ? (WTIME >> 1) - 16'd1 : WTIME - 16'd1);
    // a held byte not being consumed this edge blocks the new one
    assign w_load   = r_state == RX_STOP && w_sample && w_rxd && (!r_valid || i_ready);
    assign o_data   = r_data;
    assign o_valid  = r_valid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:      if (r_prev && !w_rxd) w_next = RX_START;
            RX_START:     if (w_sample) w_next = w_rxd ? RX_IDLE : RX_DATA;
            RX_DATA:      if (w_sample && r_bit == 3'(DATA_BITS - 1)) w_next = RX_STOP;
            RX_STOP:      if (w_sample) w_next = w_rxd ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_rxd) w_next = RX_IDLE;
            default:      w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= RX_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync  <= 2'b11;
            r_prev  <= 1'b1;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_prev <= w_rxd;
            r_cnt  <= (r_state == RX_IDLE || r_state == RX_WAIT_HIGH || w_sample) ? 16'd0 : r_cnt + 16'd1;
            if (r_state == RX_DATA && w_sample) begin
                r_shift <= {w_rxd, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/serial_interface.sv
// serial_interface: full-duplex 8N1 UART with ready-valid byte ports
// Ports: clk, nrst (async active-low), uart_txd_in (serial in), uart_rxd_out (serial out),
//        i_data/i_valid/i_ready (bytes to send), o_data/o_valid/o_ready (bytes received)
module serial_interface
    import serial_pkg::*;
#(
    parameter logic [15:0] WTIME = 16'd868
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       uart_txd_in,
    output logic       uart_rxd_out,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       o_ready
);
    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_txd, r_ready;
    logic        w_accept, w_bit_end, w_last_bit;

    assign w_accept     = i_valid && r_ready;
    assign w_bit_end    = r_tx_cnt == WTIME - 16'd1;
    assign w_last_bit   = r_tx_bit == (r_tx_state == TX_DATA ? 3'(DATA_BITS - 1) : 3'(STOP_BITS - 1));
    assign uart_rxd_out = r_txd;
    assign i_ready      = r_ready;

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_accept) w_tx_next = TX_START;
            TX_START: if (w_bit_end) w_tx_next = TX_DATA;
            TX_DATA:  if (w_bit_end && w_last_bit) w_tx_next = TX_STOP;
            TX_STOP:  if (w_bit_end && w_last_bit) w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_tx_state <= TX_IDLE;
        else       r_tx_state <= w_tx_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_txd      <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_tx_cnt <= (r_tx_state == TX_IDLE || w_bit_end) ? 16'd0 : r_tx_cnt + 16'd1;
            case (r_tx_state)
                TX_IDLE: begin
                    // rises on the first edge out of reset, falls on accept
                    r_ready <= !w_accept;
                    if (w_accept) begin
                        r_txd      <= 1'b0;
                        r_tx_shift <= i_data;
                    end
                end
                TX_START: if (w_bit_end) begin
                    r_txd    <= r_tx_shift[0];
                    r_tx_bit <= 3'd0;
                end
                TX_DATA: if (w_bit_end) begin
                    r_txd      <= w_last_bit ? 1'b1 : r_tx_shift[1];
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= w_last_bit ? 3'd0 : r_tx_bit + 3'd1;
                end
                TX_STOP: if (w_bit_end) begin
                    r_tx_bit <= w_last_bit ? 3'd0 : r_tx_bit + 3'd1;
                    r_ready  <= w_last_bit;
                end
            endcase
        end
    end

    serial_rx #(.WTIME(WTIME)) u_rx (
        .clk     (clk),
        .nrst    (nrst),
        .i_rxd   (uart_txd_in),
        .i_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid)
    );
endmodule

// File: tb/tb_serial_interface.sv
// tb_serial_interface: directed self-checking bench for serial_interface (WTIME=64)
module tb_serial_interface;
    localparam logic [15:0] W  = 16'h40;
    localparam int          WI = 64;

    logic       clk = 1'b0, nrst = 1'b0;
    logic       r_line = 1'b1, r_loop = 1'b0;
    logic [7:0] a_idata = 8'h00, b_idata = 8'h00;
    logic       a_ivalid = 1'b0, b_ivalid = 1'b0, a_oready = 1'b1, b_oready = 1'b1;
    logic       a_txd, b_txd, a_irdy, b_irdy, a_ovalid, b_ovalid;
    logic [7:0] a_odata, b_odata;
    logic       w_a_rx;
    int         n_chk = 0, n_pass = 0, a_vcnt = 0, b_vcnt = 0;

    assign w_a_rx = r_loop ? b_txd : r_line;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_ovalid) a_vcnt++;
        if (b_ovalid) b_vcnt++;
    end

    serial_interface #(.WTIME(W)) dut (
        .clk(clk), .nrst(nrst), .uart_txd_in(w_a_rx), .uart_rxd_out(a_txd),
        .i_data(a_idata), .i_valid(a_ivalid), .i_ready(a_irdy),
        .o_data(a_odata), .o_valid(a_ovalid), .o_ready(a_oready)
    );

    serial_interface #(.WTIME(W)) peer (
        .clk(clk), .nrst(nrst), .uart_txd_in(a_txd), .uart_rxd_out(b_txd),
        .i_data(b_idata), .i_valid(b_ivalid), .i_ready(b_irdy),
        .o_data(b_odata), .o_valid(b_ovalid), .o_ready(b_oready)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            r_line = f[i];
            cyc(WI);
        end
        r_line = 1'b1;
    endtask

    task automatic wait_valid(input int lim, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            cyc(1);
            seen = a_ovalid;
        end
    endtask

    initial begin
        logic       seen, exp_line;
        logic [9:0] frame;
        int         bad_line, bad_rdy, v0, vb;

        cyc(2);
        check("rst_txd", 16'(a_txd), 16'd1);
        check("rst_irdy", 16'(a_irdy), 16'd0);
        check("rst_ovalid", 16'(a_ovalid), 16'd0);
        check("rst_odata", 16'(a_odata), 16'h00);
        nrst = 1'b1;
        #1 check("rel_irdy_pre", 16'(a_irdy), 16'd0);
        cyc(1);
        check("rel_irdy", 16'(a_irdy), 16'd1);

        // transmit 0xAB: start, 1,1,0,1,0,1,0,1, stop
        v0 = b_vcnt;
        a_idata = 8'hAB;
        a_ivalid = 1'b1;
        cyc(1);
        a_ivalid = 1'b0;
        frame = 10'b1_1010_1011_0;
        bad_line = 0;
        bad_rdy = 0;
        for (int j = 0; j <= 10 * WI; j++) begin
            exp_line = (j / WI >= 10) ? 1'b1 : frame[j / WI];
            if (a_txd !== exp_line) bad_line++;
            if (a_irdy !== (j >= 10 * WI)) bad_rdy++;
            if (j % WI == WI / 2) check($sformatf("tx_bit%0d", j / WI), 16'(a_txd), 16'(exp_line));
            if (j == 10 * WI - 1) check("tx_rdy_low_last", 16'(a_irdy), 16'd0);
            if (j == 10 * WI) check("tx_rdy_back", 16'(a_irdy), 16'd1);
            if (j < 10 * WI) cyc(1);
        end
        check("tx_line_all", 16'(bad_line), 16'd0);
        check("tx_rdy_all", 16'(bad_rdy), 16'd0);
        check("peer_rx_pulses", 16'(b_vcnt - v0), 16'd1);
        check("peer_rx_data", 16'(b_odata), 16'h00AB);

        // loopback: peer transmits 0xAB into dut receiver
        r_loop = 1'b1;
        v0 = a_vcnt;
        b_idata = 8'hAB;
        b_ivalid = 1'b1;
        cyc(1);
        b_ivalid = 1'b0;
        wait_valid(12 * WI, seen);
        check("lb_seen", 16'(seen), 16'd1);
        check("lb_data", 16'(a_odata), 16'h00AB);
        cyc(2 * WI);
        check("lb_pulses", 16'(a_vcnt - v0), 16'd1);
        r_loop = 1'b0;

        // overrun: second byte dropped while first is held
        a_oready = 1'b0;
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        cyc(WI);
        check("ovr_valid", 16'(a_ovalid), 16'd1);
        check("ovr_data", 16'(a_odata), 16'h0012);
        a_oready = 1'b1;
        cyc(1);
        a_oready = 1'b0;
        check("ovr_drain", 16'(a_ovalid), 16'd0);

        // framing error then a good frame
        v0 = a_vcnt;
        send_frame(8'h55, 1'b0);
        cyc(WI);
        check("fe_novalid", 16'(a_vcnt - v0), 16'd0);
        send_frame(8'hC3, 1'b1);
        wait_valid(2 * WI, seen);
        check("fe_next_seen", 16'(seen), 16'd1);
        check("fe_next_data", 16'(a_odata), 16'h00C3);
        a_oready = 1'b1;
        cyc(1);
        check("fe_next_drain", 16'(a_ovalid), 16'd0);

        // 20-cycle glitch
        v0 = a_vcnt;
        r_line = 1'b0;
        cyc(20);
        r_line = 1'b1;
        cyc(12 * WI);
        check("glitch_novalid", 16'(a_vcnt - v0), 16'd0);

        // reset during transmission of 0x5A (line low in d2 at 3 bit times)
        v0 = a_vcnt;
        vb = b_vcnt;
        a_idata = 8'h5A;
        a_ivalid = 1'b1;
        cyc(1);
        a_ivalid = 1'b0;
        cyc(3 * WI);
        check("mrst_pre_txd", 16'(a_txd), 16'd0);
        nrst = 1'b0;
        #1;
        check("mrst_txd", 16'(a_txd), 16'd1);
        check("mrst_irdy", 16'(a_irdy), 16'd0);
        cyc(2);
        nrst = 1'b1;
        #1 check("mrst_irdy_pre", 16'(a_irdy), 16'd0);
        cyc(1);
        check("mrst_irdy_back", 16'(a_irdy), 16'd1);
        cyc(12 * WI);
        check("mrst_a_novalid", 16'(a_vcnt - v0), 16'd0);
        check("mrst_b_novalid", 16'(b_vcnt - vb), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_interface.md
SERIAL_INTERFACE -- requirements
Module: serial_interface

Interface
REQ-001 SHALL have parameter WTIME, default 16'd868, 16-bit count of clk cycles per UART bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port nrst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port uart_txd_in  input  1  serial receive line, idle high, asynchronous to clk.
REQ-005 SHALL have port uart_rxd_out  output  1  serial transmit line, idle high.
REQ-006 SHALL have port i_data  input  8  byte to transmit.
REQ-007 SHALL have port i_valid  input  1  i_data valid.
REQ-008 SHALL have port i_ready  output  1  transmitter can accept a byte.
REQ-009 SHALL have port o_data  output  8  received byte.
REQ-010 SHALL have port o_valid  output  1  o_data valid.
REQ-011 SHALL have port o_ready  input  1  consumer accepts o_data.

Function
REQ-012 SHALL use 8N1 framing: start bit 0, 8 data bits LSB first, one stop bit 1, each bit WTIME cycles.
REQ-013 SHALL accept a transmit byte on a rising edge where i_valid and i_ready are both 1; i_data SHALL be captured at that edge.
REQ-014 SHALL drive uart_rxd_out low starting the cycle after acceptance, then d0..d7, then stop bit, each held exactly WTIME cycles, all from a register.
REQ-015 SHALL deassert i_ready the cycle after acceptance and reassert it exactly 10*WTIME cycles after acceptance; a new byte may be accepted in that cycle with no idle gap.
REQ-016 Transmitter states SHALL be IDLE, START, DATA, STOP; IDLE->START on accept, START->DATA after WTIME, DATA->STOP after 8 bits, STOP->IDLE after WTIME.
REQ-017 SHALL synchronise uart_txd_in through two flip-flops before any use.
REQ-018 Receiver SHALL detect start on a synchronised 1->0 transition while idle, and SHALL re-sample at WTIME/2 (integer floor); if high, SHALL return to idle (glitch reject).
REQ-019 SHALL sample each data bit and the stop bit at bit centre, i.e. WTIME cycles after the previous sample.
REQ-020 If the stop-bit sample is 1, SHALL load o_data and set o_valid in the cycle after that sample; if 0 (framing error), SHALL discard the byte and await line high before seeking a new start.
REQ-021 o_valid and o_data SHALL stay stable until an edge with o_valid and o_ready both 1; o_valid SHALL drop the following cycle unless a new byte loads simultaneously.
REQ-022 If a byte completes while o_valid=1 and o_ready=0 (overrun), SHALL drop the new byte and keep the held one.
REQ-023 Receiver states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; transmitter and receiver SHALL operate fully independently (full duplex).

Reset
REQ-024 While nrst=0: uart_rxd_out=1, i_ready=0, o_valid=0, o_data=8'h00, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-025 i_ready SHALL become 1 on the first clk edge after nrst deasserts.
REQ-026 Reset mid-frame SHALL abort the frame immediately; no partial byte SHALL be delivered afterwards.

Structure
REQ-027 Package serial_pkg SHALL hold DATA_BITS=8, STOP_BITS=1, and the tx_state_t and rx_state_t enums.
REQ-028 Receiver SHALL be sub-module serial_rx (synchroniser, FSM, output buffer); transmitter SHALL be inline in serial_interface.

Verification
REQ-029 WTIME=16'h40: send 8'hAB after reset -> uart_rxd_out low 64 cycles, then bits 1,1,0,1,0,1,0,1 each 64 cycles, then high; i_ready back high 640 cycles after accept.
REQ-030 Loopback of two instances (txd of one to rxd of other), 8'hAB sent -> receiving o_valid=1, o_data=8'hAB, exactly one pulse with o_ready=1.
REQ-031 o_ready=0, send 8'h12 then 8'h34 -> o_data stays 8'h12 (overrun drops 8'h34); after o_ready=1 for one cycle, o_valid=0.
REQ-032 Drive frame for 8'h55 with stop bit 0 -> o_valid never asserts; following valid frame 8'hC3 -> received correctly.
REQ-033 20-cycle low glitch on uart_txd_in (WTIME=64) -> no o_valid.
REQ-034 Pulse nrst low mid-transmission -> uart_rxd_out=1 and i_ready=0 immediately, i_ready=1 one edge after release, nothing delivered on o_valid.
